// File: rtl/grey_frame_writer_if.sv
// Pixel-side and write-port signals of grey_frame_writer, bundled.
// The slave modport is the scheduler's view; master is the packer/memory side.
interface grey_frame_writer_if #(
   parameter int output_width = 15,
   parameter int addr_width   = 20
) ();
   logic                    f_val;
   logic                    d_val;
   logic [output_width-1:0] data_in1;
   logic [output_width-1:0] data_in2;
   logic                    wr_ready;
   logic                    wr_en;
   logic [output_width-1:0] wr_data;
   logic [addr_width-1:0]   wr_addr;

   modport master (
      output f_val, d_val, data_in1, data_in2, wr_ready,
      input  wr_en, wr_data, wr_addr
   );

   modport slave (
      input  f_val, d_val, data_in1, data_in2, wr_ready,
      output wr_en, wr_data, wr_addr
   );
endinterface

// File: rtl/grey_frame_writer.sv
// Frame-synchronous write scheduler: buffers up to two pixels and serialises
// each into two word writes at frame-relative addresses 2*index and 2*index+1.
module grey_frame_writer #(
   parameter int num_rows     = 480,
   parameter int num_cols     = 640,
   parameter int output_width = 15,
   parameter int addr_width   = 20
) (
   input  logic                  clk,
   input  logic                  rst,
   grey_frame_writer_if.slave    wr_if,
   output logic                  frame_start,
   output logic                  frame_done,
   output logic                  overflow,
   output logic [addr_width-1:0] pix_count,
   output logic                  busy
);
   localparam logic [addr_width-1:0] idx_limit = addr_width'(num_rows * num_cols);

   typedef enum logic [1:0] {IDLE, WAIT, ACTIVE, DRAIN} state_t;

   state_t                  state_reg, state_next;
   logic                    f_val_reg;
   logic [addr_width-1:0]   idx_reg;
   logic [1:0]              count_reg;
   logic                    rd_ptr_reg, wr_ptr_reg, phase_reg;
   logic                    start_next, done_next;

   logic [output_width-1:0] word1_mem [2];
   logic [output_width-1:0] word2_mem [2];
   logic [addr_width-1:0]   base_mem  [2];

   logic                    not_empty, xfer, pop, pix_valid, in_range, push, drop;
   logic [addr_width-1:0]   base_addr;

   assign not_empty = (count_reg != 2'd0);
   assign xfer      = not_empty & wr_if.wr_ready;
   assign pop       = xfer & phase_reg;
   assign pix_valid = (state_reg == ACTIVE) & wr_if.f_val & wr_if.d_val;
   assign in_range  = (idx_reg < idx_limit);
   // A full buffer still accepts when the head pixel's second word leaves now.
   assign push      = pix_valid & in_range & ((count_reg != 2'd2) | pop);
   assign drop      = pix_valid & ~push;
   assign base_addr = {idx_reg[addr_width-2:0], 1'b0};

   assign wr_if.wr_en   = xfer;
   assign wr_if.wr_data = !not_empty ? '0 :
                          (phase_reg ? word2_mem[rd_ptr_reg] : word1_mem[rd_ptr_reg]);
   assign wr_if.wr_addr = !not_empty ? '0 :
                          base_mem[rd_ptr_reg] + addr_width'(phase_reg);

   always_comb begin
      state_next = state_reg;
      start_next = 1'b0;
      done_next  = 1'b0;
      case (state_reg)
         IDLE:   if (!wr_if.f_val) state_next = WAIT;
         WAIT: begin
            if (!f_val_reg && wr_if.f_val) begin
               state_next = ACTIVE;
               start_next = 1'b1;
            end
         end
         ACTIVE: if (!wr_if.f_val) state_next = DRAIN;
         DRAIN: begin
            // Finish as soon as the buffer is empty after this cycle's transfer.
            if (count_reg == 2'd0 || (count_reg == 2'd1 && pop)) begin
               state_next = WAIT;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         f_val_reg   <= 1'b0;
         idx_reg     <= '0;
         count_reg   <= 2'd0;
         rd_ptr_reg  <= 1'b0;
         wr_ptr_reg  <= 1'b0;
         phase_reg   <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         overflow    <= 1'b0;
         pix_count   <= '0;
         busy        <= 1'b0;
      end else begin
         state_reg   <= state_next;
         f_val_reg   <= wr_if.f_val;
         frame_start <= start_next;
         frame_done  <= done_next;
         busy        <= (state_next == ACTIVE) || (state_next == DRAIN);

         if (start_next)
            overflow <= 1'b0;
         else if (drop)
            overflow <= 1'b1;

         // Dropped pixels still consume an index so geometry is preserved.
         if (start_next)
            idx_reg <= '0;
         else if (pix_valid && in_range)
            idx_reg <= idx_reg + 1'b1;

         if (start_next)
            pix_count <= '0;
         else if (pop)
            pix_count <= pix_count + 1'b1;

         if (push)
            wr_ptr_reg <= ~wr_ptr_reg;

         if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
            phase_reg  <= 1'b0;
         end else if (xfer) begin
            phase_reg  <= 1'b1;
         end

         case ({push, pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (push && wr_ptr_reg == 1'(gi)) begin
               word1_mem[gi] <= wr_if.data_in1;
               word2_mem[gi] <= wr_if.data_in2;
               base_mem[gi]  <= base_addr;
            end
         end
      end
   endgenerate
endmodule
